instruction_sequencer: RTL and testbench

//  Upstream feeder for control_circuit: holds a small program of 11-bit instructions
//  {opcode[2:0], rx[3:0], ry_or_data[3:0]}, fetches them in order and presents each on

---
 rtl/instruction_sequencer_pkg.sv | 33 +++
 rtl/instruction_sequencer_instr_mem.sv | 33 +++
 rtl/instruction_sequencer.sv | 137 +++++++++++++
 tb/tb_instruction_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: instruction layout,
// opcode and register codes, and the sequencer state encoding.
package instruction_sequencer_pkg;

   localparam int INSTR_W = 11;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;

   // Opcodes understood by control_circuit; anything with bit 2 set is undefined
   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;

   // Register codes for the rx / ry fields
   localparam logic [3:0] REG_R1 = 4'b0001;
   localparam logic [3:0] REG_R2 = 4'b0010;
   localparam logic [3:0] REG_R3 = 4'b0011;
   localparam logic [3:0] REG_R4 = 4'b0100;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_ISSUE  = 3'd2;
   localparam logic [2:0] ST_FINISH = 3'd3;
   localparam logic [2:0] ST_ERROR  = 3'd4;

   // Opcodes 3'b1xx are undefined and must never reach control_circuit
   function automatic logic opcode_illegal(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/instruction_sequencer_instr_mem.sv
// Program memory: synchronous write, registered read, no reset.
// A write to the address being read in the same cycle returns the new data,
// so a program written on the start cycle is the one that gets fetched.
module instruction_sequencer_instr_mem
   import instruction_sequencer_pkg::*;
#(
   parameter int W  = INSTR_W,
   parameter int D  = DEPTH,
   parameter int AW = ADDR_W
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [D];

   // Write port plus registered read with write-first forwarding
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem_q[raddr];
      end
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches the stored program in order and hands each
// instruction to control_circuit, holding it until Done. Halts on an
// undefined opcode, on reaching last_addr, or on a stop request.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic [ADDR_W-1:0]  last_addr,
   input  logic               start,
   input  logic               stop,
   input  logic               Done,
   output logic [INSTR_W-1:0] INSTRUCTION,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               finished,
   output logic               err
);

   logic [2:0]         state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  last_q, last_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;
   logic               fin_q, fin_d;
   logic               err_q, err_d;
   logic               stop_pend_q, stop_pend_d;
   logic [INSTR_W-1:0] rd_data;
   logic               busy_w;

   assign busy_w = (state_q == ST_FETCH) || (state_q == ST_ISSUE);

   // The read address is the next pc, so the word for pc is ready during FETCH
   instruction_sequencer_instr_mem u_mem (
      .clk   (clk),
      .we    (prog_we && !busy_w),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (pc_d),
      .rdata (rd_data)
   );

   // Next-state logic: FSM transitions, pc advance, stop latch and sticky flags
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      last_d      = last_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      fin_d       = fin_q;
      err_d       = err_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         ST_IDLE, ST_FINISH, ST_ERROR: begin
            if (start) begin
               state_d     = ST_FETCH;
               pc_d        = '0;
               last_d      = last_addr;
               fin_d       = 1'b0;
               err_d       = 1'b0;
               stop_pend_d = 1'b0;
            end
         end
         ST_FETCH: begin
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            if (opcode_illegal(rd_data[INSTR_W-1 -: 3])) begin
               state_d     = ST_ERROR;
               err_d       = 1'b1;
               stop_pend_d = 1'b0;
            end else begin
               state_d = ST_ISSUE;
               instr_d = rd_data;
               valid_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (Done) begin
               valid_d = 1'b0;
               if (pc_q == last_q) begin
                  state_d     = ST_FINISH;
                  fin_d       = 1'b1;
                  stop_pend_d = 1'b0;
               end else if (stop_pend_q || stop) begin
                  state_d     = ST_IDLE;
                  stop_pend_d = 1'b0;
               end else begin
                  state_d = ST_FETCH;
                  pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end else if (stop) begin
               stop_pend_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State registers; reset abandons any instruction in flight, memory is untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         last_q      <= '0;
         instr_q     <= '0;
         valid_q     <= 1'b0;
         fin_q       <= 1'b0;
         err_q       <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         last_q      <= last_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         fin_q       <= fin_d;
         err_q       <= err_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   assign INSTRUCTION = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = busy_w;
   assign finished    = fin_q;
   assign err         = err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: table of whole-program runs,
// hand-written corner sequences, and randomized programs against a
// transaction-level reference model.
module tb_instruction_sequencer;
   import instruction_sequencer_pkg::*;

   logic               clk;
   logic               reset;
   logic               prog_we;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [ADDR_W-1:0]  last_addr;
   logic               start;
   logic               stop;
   logic               Done;
   logic [INSTR_W-1:0] INSTRUCTION;
   logic               instr_valid;
   logic [ADDR_W-1:0]  pc;
   logic               busy;
   logic               finished;
   logic               err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [INSTR_W-1:0] prog_m [DEPTH];

   instruction_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .last_addr   (last_addr),
      .start       (start),
      .stop        (stop),
      .Done        (Done),
      .INSTRUCTION (INSTRUCTION),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .finished    (finished),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] last;
      int         dly;
      int         stop_idx;
      int         exp_n;
      logic       exp_fin;
      logic       exp_err;
      logic [3:0] exp_pc;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [INSTR_W-1:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
      prog_m[a] = d;
   endtask

   // Reference: walk the program from 0; undefined opcode stops with err,
   // reaching last finishes, a stop during entry i halts after entry i.
   function automatic void model(input logic [3:0] last, input int stop_idx,
                                 output int n, output logic fin, output logic er,
                                 output logic [3:0] pcx);
      n = 0; fin = 1'b0; er = 1'b0; pcx = 4'd0;
      for (int i = 0; i <= int'(last); i++) begin
         pcx = 4'(i);
         if (prog_m[i][10]) begin
            er = 1'b1;
            return;
         end
         n++;
         if (i == int'(last)) begin
            fin = 1'b1;
            return;
         end
         if (i == stop_idx) return;
      end
   endfunction

   // Run one program. mode 1: write addr0 while busy (must be ignored);
   // mode 2: write addr0 in the start cycle (must be honoured and fetched).
   task automatic run(input logic [3:0] last, input int dly, input int stop_idx,
                      input int mode, input logic [INSTR_W-1:0] wdat, output int n_iss);
      int cyc;
      int gap;
      n_iss = 0;
      cyc = 0;
      @(negedge clk);
      last_addr = last;
      start = 1'b1;
      if (mode == 2) begin
         prog_we = 1'b1; prog_addr = 4'd0; prog_data = wdat;
         prog_m[0] = wdat;
      end
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      gap = 1;
      while (busy && cyc < 500) begin
         if (instr_valid) begin
            chk("latency", gap, 2);
            chk("instr", INSTRUCTION, (n_iss < DEPTH) ? prog_m[n_iss] : '0);
            chk("issue_pc", pc, n_iss);
            if (mode == 1 && n_iss == 0) begin
               prog_we = 1'b1; prog_addr = 4'd0; prog_data = wdat;
            end
            if (n_iss == stop_idx) stop = 1'b1;
            for (int w = 0; w < dly; w++) begin
               @(negedge clk);
               stop = 1'b0; prog_we = 1'b0;
               cyc++;
            end
            chk("hold_valid", instr_valid, 1);
            Done = 1'b1;
            @(negedge clk);
            Done = 1'b0; stop = 1'b0; prog_we = 1'b0;
            n_iss++;
            gap = 1;
         end else begin
            @(negedge clk);
            gap++;
         end
         cyc++;
      end
      chk("run_timeout", (cyc < 500), 1);
   endtask

   initial begin
      int n, en, cyc;
      logic efin, eerr;
      logic [3:0] epc;
      logic [INSTR_W-1:0] orig0;

      reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
      last_addr = '0; start = 1'b0; stop = 1'b0; Done = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_instr", INSTRUCTION, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_pc", pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fin", finished, 0);
      chk("rst_err", err, 0);

      // Fixed program: four-instruction demo, filler, one undefined opcode at 9
      wr(4'd0, {OP_LOAD, REG_R1, 4'b0110});
      wr(4'd1, {OP_MOV,  REG_R1, REG_R2});
      wr(4'd2, {OP_ADD,  REG_R3, REG_R4});
      wr(4'd3, {OP_SUB,  REG_R2, REG_R4});
      for (int i = 4; i < DEPTH; i++) begin
         logic [3:0] ia;
         ia = 4'(i);
         wr(ia, {1'b0, ia[1:0], ia, ~ia});
      end
      wr(4'd9, 11'b110_1001_0000);

      tbl[0] = '{4'd3,  3, -1, 4, 1'b1, 1'b0, 4'd3};
      tbl[1] = '{4'd0,  0, -1, 1, 1'b1, 1'b0, 4'd0};
      tbl[2] = '{4'd3,  5,  1, 2, 1'b0, 1'b0, 4'd1};
      tbl[3] = '{4'd15, 1, -1, 9, 1'b0, 1'b1, 4'd9};
      tbl[4] = '{4'd8,  2, -1, 9, 1'b1, 1'b0, 4'd8};
      tbl[5] = '{4'd3,  0,  3, 4, 1'b1, 1'b0, 4'd3};
      tbl[6] = '{4'd6,  2,  4, 5, 1'b0, 1'b0, 4'd4};

      for (int t = 0; t < 7; t++) begin
         run(tbl[t].last, tbl[t].dly, tbl[t].stop_idx, 0, '0, n);
         chk("tbl_count", n, tbl[t].exp_n);
         chk("tbl_fin", finished, tbl[t].exp_fin);
         chk("tbl_err", err, tbl[t].exp_err);
         chk("tbl_pc", pc, tbl[t].exp_pc);
         chk("tbl_busy", busy, 0);
         $display("table row %0d: issued=%0d fin=%0d err=%0d pc=%0d", t, n, finished, err, pc);
      end

      // Undefined opcode at entry 1: entry 0 issued, then ERROR without issuing entry 1
      wr(4'd1, 11'b101_0101_0101);
      run(4'd3, 2, -1, 0, '0, n);
      chk("illegal_count", n, 1);
      chk("illegal_err", err, 1);
      chk("illegal_pc", pc, 1);
      chk("illegal_valid", instr_valid, 0);
      $display("illegal opcode run: issued=%0d err=%0d", n, err);
      wr(4'd1, {OP_MOV, REG_R1, REG_R2});

      // Reset while entry 2 is awaiting Done
      @(negedge clk);
      last_addr = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; cyc = 0;
      while (n < 2 && cyc < 200) begin
         if (instr_valid) begin
            @(negedge clk);
            Done = 1'b1;
            @(negedge clk);
            Done = 1'b0;
            n++;
         end else @(negedge clk);
         cyc++;
      end
      while (!instr_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("midrst_pre_pc", pc, 2);
      chk("midrst_pre_valid", instr_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_instr", INSTRUCTION, 0);
      chk("midrst_valid", instr_valid, 0);
      chk("midrst_pc", pc, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_fin", finished, 0);
      chk("midrst_err", err, 0);
      run(4'd3, 1, -1, 0, '0, n);
      chk("after_rst_count", n, 4);
      chk("after_rst_fin", finished, 1);
      $display("reset mid-issue: rerun issued=%0d", n);

      // Done held high: each instruction valid one cycle, two-cycle spacing
      Done = 1'b1;
      @(negedge clk);
      last_addr = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("dh_valid", instr_valid, (k % 2 == 0));
         if (k % 2 == 0) chk("dh_instr", INSTRUCTION, prog_m[k/2 - 1]);
         @(negedge clk);
      end
      chk("dh_fin", finished, 1);
      chk("dh_busy", busy, 0);
      repeat (4) @(negedge clk);
      chk("dh_spurious_fin", finished, 1);
      chk("dh_spurious_pc", pc, 3);
      chk("dh_spurious_valid", instr_valid, 0);
      Done = 1'b0;
      $display("done-held run: fin=%0d pc=%0d", finished, pc);

      // Write to entry 0 while busy is dropped; rerun sees original entry 0
      run(4'd3, 1, -1, 1, 11'h7FF, n);
      chk("we_busy_count1", n, 4);
      run(4'd3, 1, -1, 0, '0, n);
      chk("we_busy_count2", n, 4);
      chk("we_busy_fin", finished, 1);
      $display("write while busy: rerun issued=%0d", n);

      // Write and start in the same cycle: the new entry 0 is issued
      orig0 = prog_m[0];
      run(4'd1, 1, -1, 2, {OP_ADD, REG_R4, REG_R3}, n);
      chk("we_start_count", n, 2);
      $display("write with start: issued=%0d", n);
      wr(4'd0, orig0);

      // Randomized programs checked against the reference model
      for (int r = 0; r < 20; r++) begin
         logic [3:0] rl;
         int rd, rs;
         for (int i = 0; i < DEPTH; i++) begin
            logic [INSTR_W-1:0] d;
            d = INSTR_W'($urandom);
            if ($urandom_range(7) != 0) d[10] = 1'b0;
            wr(4'(i), d);
         end
         rl = 4'($urandom_range(15));
         rd = int'($urandom_range(3));
         rs = ($urandom_range(2) == 0) ? int'($urandom_range(15)) : -1;
         model(rl, rs, en, efin, eerr, epc);
         run(rl, rd, rs, 0, '0, n);
         chk("rnd_count", n, en);
         chk("rnd_fin", finished, efin);
         chk("rnd_err", err, eerr);
         chk("rnd_pc", pc, epc);
         $display("random %0d: last=%0d stop=%0d issued=%0d exp=%0d", r, rl, rs, n, en);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
